alu_op_sequencer: RTL and testbench

Sequences the shared ALU for the datapath. Accepts one operation request (opcode, X, Y) over a valid/ready handshake and drives the ALU's one-hot control vector and operands for the required number of cycles. Captures the 2*BITS-wide ALU result into Z_HI/Z_LO registers and presents it over an output valid/ready handshake. Sits between the control unit and the ALU and replaces ad-hoc direct driving of the ALU control lines.

---
 rtl/alu_op_sequencer.sv | 170 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Sequences the shared ALU. Accepts one request (opcode, X, Y) over a
//   valid/ready handshake. It then drives the ALU one-hot control vector and
//   the operands for the number of cycles the operation needs. It captures the
//   2*BITS-wide ALU result into z_hi/z_lo and presents that result over an
//   output valid/ready handshake.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   clr        : synchronous active-high reset, priority over all inputs
//   in_valid   : request present
//   in_ready   : sequencer can accept a request (IDLE only)
//   in_op      : opcode, selects ALU control bit in_op
//   in_x/in_y  : signed operands
//   alu_ctrl   : one-hot ALU control vector, nonzero only in EXEC
//   alu_x/y    : operands latched at accept, driven to the ALU
//   alu_result : ALU result, sampled on the last EXEC edge only
//   out_valid  : result available
//   out_ready  : consumer takes result
//   z_hi/z_lo  : upper/lower halves of the captured result
//   err        : illegal opcode flag, valid while out_valid
module alu_op_sequencer #(
  parameter int BITS          = 32,
  parameter int SIG_COUNT     = 13,
  parameter int OPW           = 4,
  parameter int MUL_OP        = 2,
  parameter int DIV_OP        = 3,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPW-1:0]       in_op,
  input  logic [BITS-1:0]      in_x,
  input  logic [BITS-1:0]      in_y,
  output logic [SIG_COUNT-1:0] alu_ctrl,
  output logic [BITS-1:0]      alu_x,
  output logic [BITS-1:0]      alu_y,
  input  logic [2*BITS-1:0]    alu_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITS-1:0]      z_hi,
  output logic [BITS-1:0]      z_lo,
  output logic                 err
);

  localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SIG_COUNT-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [BITS-1:0]      alu_x_q, alu_x_d;
  logic [BITS-1:0]      alu_y_q, alu_y_d;
  logic [BITS-1:0]      z_hi_q, z_hi_d;
  logic [BITS-1:0]      z_lo_q, z_lo_d;
  logic                 out_valid_q, out_valid_d;
  logic                 err_q, err_d;

  logic op_legal;
  logic op_muldiv;

  assign op_legal  = (32'(in_op) < SIG_COUNT);
  assign op_muldiv = (in_op == OPW'(MUL_OP)) || (in_op == OPW'(DIV_OP));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_x_d     = alu_x_q;
    alu_y_d     = alu_y_q;
    z_hi_d      = z_hi_q;
    z_lo_d      = z_lo_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        alu_ctrl_d = '0;
        if (in_valid) begin
          if (op_legal) begin
            state_d    = EXEC;
            // The control vector is registered, so the decoded bit appears
            // exactly in the first EXEC cycle.
            alu_ctrl_d = SIG_COUNT'(1) << in_op;
            alu_x_d    = in_x;
            alu_y_d    = in_y;
            cnt_d      = op_muldiv ? CW'(MULDIV_CYCLES - 1) : '0;
          end else begin
            // An illegal opcode skips EXEC entirely, so the ALU is never
            // driven for it.
            state_d     = DONE;
            out_valid_d = 1'b1;
            err_d       = 1'b1;
            z_hi_d      = '0;
            z_lo_d      = '0;
          end
        end
      end

      EXEC: begin
        if (cnt_q == '0) begin
          state_d     = DONE;
          alu_ctrl_d  = '0;
          z_hi_d      = alu_result[2*BITS-1:BITS];
          z_lo_d      = alu_result[BITS-1:0];
          out_valid_d = 1'b1;
          err_d       = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          err_d       = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        alu_ctrl_d  = '0;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_ctrl_q  <= '0;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      z_hi_q      <= '0;
      z_lo_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_x_q     <= alu_x_d;
      alu_y_q     <= alu_y_d;
      z_hi_q      <= z_hi_d;
      z_lo_q      <= z_lo_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign alu_ctrl  = alu_ctrl_q;
  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign z_hi      = z_hi_q;
  assign z_lo      = z_lo_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer. It uses a behavioural ALU model and a table
// of directed vectors with hand-computed results. Hand-written sequences
// cover backpressure, reset in the middle of EXEC, and back-to-back requests.
module tb_alu_op_sequencer;

  logic        clk;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic [12:0] alu_ctrl;
  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic [63:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z_hi;
  logic [31:0] z_lo;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  alu_op_sequencer #(
    .BITS(32), .SIG_COUNT(13), .OPW(4), .MUL_OP(2), .DIV_OP(3), .MULDIV_CYCLES(4)
  ) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_x(in_x), .in_y(in_y), .alu_ctrl(alu_ctrl),
    .alu_x(alu_x), .alu_y(alu_y), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .z_hi(z_hi), .z_lo(z_lo),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: 0 add, 1 sub, 2 mul, 3 div {rem,quot}, 4 and, other {x,y}
  logic [63:0] xs, ys;
  always_comb begin
    xs = {{32{alu_x[31]}}, alu_x};
    ys = {{32{alu_y[31]}}, alu_y};
    alu_result = '0;
    if (alu_ctrl[0])      alu_result = xs + ys;
    else if (alu_ctrl[1]) alu_result = xs - ys;
    else if (alu_ctrl[2]) alu_result = xs * ys;
    else if (alu_ctrl[3]) begin
      if (alu_y != 32'd0)
        alu_result = {32'($signed(alu_x) % $signed(alu_y)),
                      32'($signed(alu_x) / $signed(alu_y))};
    end
    else if (alu_ctrl[4]) alu_result = {32'h0, alu_x & alu_y};
    else if (alu_ctrl != '0) alu_result = {alu_x, alu_y};
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    int          n;     // EXEC cycles; 0 = illegal opcode
    logic [31:0] hi;
    logic [31:0] lo;
    logic        e;
  } vec_t;

  vec_t tbl[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offers one request, checks every EXEC cycle, the result, and the handshake.
  task automatic run_op(input vec_t v);
    logic [12:0] oh;
    oh = 13'd1 << v.op;
    in_valid = 1'b1; in_op = v.op; in_x = v.x; in_y = v.y;
    check("in_ready_idle", in_ready, 1);
    step();
    // Scramble inputs after accept; the latched operands must not follow.
    in_valid = 1'b0; in_op = v.op ^ 4'h1; in_x = ~v.x; in_y = ~v.y;
    for (int k = 0; k < v.n; k++) begin
      check("exec_ctrl", alu_ctrl, oh);
      check("exec_x", alu_x, v.x);
      check("exec_y", alu_y, v.y);
      check("exec_no_valid", out_valid, 0);
      check("exec_not_ready", in_ready, 0);
      step();
    end
    check("done_valid", out_valid, 1);
    check("done_ctrl", alu_ctrl, 0);
    check("done_not_ready", in_ready, 0);
    check("z_hi", z_hi, v.hi);
    check("z_lo", z_lo, v.lo);
    check("err", err, v.e);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_err", err, 0);
    check("post_ready", in_ready, 1);
    check("post_z_lo_held", z_lo, v.lo);
  endtask

  initial begin
    tbl[0] = '{op: 4'd0,  x: 32'd15,        y: 32'd5,        n: 1, hi: 32'h0,        lo: 32'd20,       e: 1'b0};
    tbl[1] = '{op: 4'd2,  x: 32'hFFFFFFF1,  y: 32'd5,        n: 4, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFB5, e: 1'b0};
    tbl[2] = '{op: 4'd1,  x: 32'd15,        y: 32'hFFFFFFFB, n: 1, hi: 32'h0,        lo: 32'd20,       e: 1'b0};
    tbl[3] = '{op: 4'd3,  x: 32'hFFFFFFEC,  y: 32'd3,        n: 4, hi: 32'hFFFFFFFE, lo: 32'hFFFFFFFA, e: 1'b0};
    tbl[4] = '{op: 4'd4,  x: 32'h0000F0F0,  y: 32'h0000FF00, n: 1, hi: 32'h0,        lo: 32'h0000F000, e: 1'b0};
    tbl[5] = '{op: 4'd13, x: 32'd7,         y: 32'd9,        n: 0, hi: 32'h0,        lo: 32'h0,        e: 1'b1};
    tbl[6] = '{op: 4'd12, x: 32'h000000A5,  y: 32'h0000005A, n: 1, hi: 32'h000000A5, lo: 32'h0000005A, e: 1'b0};
    tbl[7] = '{op: 4'd15, x: 32'd1,         y: 32'd1,        n: 0, hi: 32'h0,        lo: 32'h0,        e: 1'b1};

    clr = 1'b1; in_valid = 1'b0; in_op = '0; in_x = '0; in_y = '0; out_ready = 1'b0;
    step();
    step();
    clr = 1'b0;
    check("rst_ready", in_ready, 1);
    check("rst_ctrl", alu_ctrl, 0);
    check("rst_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_z", {z_hi, z_lo}, 0);
    check("rst_x", alu_x, 0);

    for (int i = 0; i < 8; i++) run_op(tbl[i]);

    // Backpressure: SUB 15-(-5), then a new request waits while out_ready=0.
    in_valid = 1'b1; in_op = 4'd1; in_x = 32'd15; in_y = 32'hFFFFFFFB;
    step();                                       // EXEC
    in_op = 4'd0; in_x = 32'd1; in_y = 32'd1;     // new request stays pending
    step();                                       // DONE
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", out_valid, 1);
      check("bp_z_lo", z_lo, 32'd20);
      check("bp_not_ready", in_ready, 0);
      check("bp_ctrl", alu_ctrl, 0);
      step();
    end
    out_ready = 1'b1;
    step();                                       // IDLE, pending request accepted here
    out_ready = 1'b0;
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_ctrl", alu_ctrl, 0);
    step();
    in_valid = 1'b0;
    check("bp_new_ctrl", alu_ctrl, 13'h0001);
    check("bp_new_x", alu_x, 32'd1);
    step();
    check("bp_new_valid", out_valid, 1);
    check("bp_new_z_lo", z_lo, 32'd2);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during DIV: clr present in the second EXEC cycle.
    in_valid = 1'b1; in_op = 4'd3; in_x = 32'd100; in_y = 32'd7;
    step();                                       // t+1
    in_valid = 1'b0;
    step();                                       // t+2
    clr = 1'b1;
    step();                                       // t+3
    clr = 1'b0;
    check("rdiv_ctrl", alu_ctrl, 0);
    check("rdiv_valid", out_valid, 0);
    check("rdiv_z", {z_hi, z_lo}, 0);
    check("rdiv_ready", in_ready, 1);
    step();
    check("rdiv_still_idle", out_valid, 0);
    run_op('{op: 4'd0, x: 32'd2, y: 32'd2, n: 1, hi: 32'h0, lo: 32'd4, e: 1'b0});

    // Back-to-back with out_ready tied high: accepts are 3 cycles apart.
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 4'd0; in_x = 32'd3; in_y = 32'd4;
    check("b2b_ready0", in_ready, 1);
    step();
    in_op = 4'd4; in_x = 32'h0000F0F0; in_y = 32'h0000FF00;
    check("b2b_ctrl0", alu_ctrl, 13'h0001);
    check("b2b_busy1", in_ready, 0);
    step();
    check("b2b_valid0", out_valid, 1);
    check("b2b_z0", z_lo, 32'd7);
    check("b2b_ctrl_done", alu_ctrl, 0);
    check("b2b_busy2", in_ready, 0);
    step();
    check("b2b_ready1", in_ready, 1);
    check("b2b_ctrl_idle", alu_ctrl, 0);
    step();
    in_valid = 1'b0;
    check("b2b_ctrl1", alu_ctrl, 13'h0010);
    step();
    check("b2b_valid1", out_valid, 1);
    check("b2b_z1", z_lo, 32'h0000F000);
    step();
    out_ready = 1'b0;
    check("b2b_end_ready", in_ready, 1);
    check("b2b_end_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
